// File: rtl/wt_sum_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : wt_sum_pipe                                                      |
// | Purpose  : Pipelined Wallace-tree multi-operand adder with valid/ready.     |
// |            Optional accumulator behind the CPA when WT_SUM_ACC_EN defined.  |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module wt_sum_pipe #(
  parameter int NOPS   = 4,
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int OUT_W  = WIDTH + $clog2(NOPS)
`ifdef WT_SUM_ACC_EN
  ,
  parameter int ACC_W  = OUT_W + 8
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    signed_mode,
  input  logic [NOPS*WIDTH-1:0]   ops,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef WT_SUM_ACC_EN
  output logic [ACC_W-1:0]        result,
  input  logic                    acc_clr
`else
  output logic [OUT_W-1:0]        result
`endif
);

  typedef logic [NOPS-1:0][OUT_W-1:0] vec_t;

  function automatic int num_levels();
    int n;
    int lv;
    n  = NOPS;
    lv = 0;
    for (int l = 0; l < 16; l++) begin
      if (n > 2) begin
        n  = 2 * (n / 3) + n % 3;
        lv = lv + 1;
      end
    end
    return lv;
  endfunction

  localparam int LEVELS = num_levels();

  // Number of live rows entering CSA level lvl.
  function automatic int cnt_at(input int lvl);
    int n;
    n = NOPS;
    for (int l = 0; l < 16; l++) begin
      if (l < lvl) n = 2 * (n / 3) + n % 3;
    end
    return n;
  endfunction

  function automatic int lvl_lo(input int s);
    if (STAGES == 1) return 0;
    if (s >= STAGES - 1) return LEVELS;
    return s * LEVELS / (STAGES - 1);
  endfunction

  function automatic int lvl_hi(input int s);
    if (STAGES == 1 || s >= STAGES - 1) return LEVELS;
    return (s + 1) * LEVELS / (STAGES - 1);
  endfunction

  // One 3:2 level: each full triple becomes sum+carry, leftovers pass through.
  function automatic vec_t csa_level(input vec_t v, input int n);
    vec_t             o;
    logic [OUT_W-1:0] maj;
    int               g;
    o = '0;
    g = n / 3;
    for (int i = 0; i < NOPS / 3; i++) begin
      if (i < g) begin
        maj        = (v[3*i] & v[3*i+1]) | (v[3*i] & v[3*i+2]) | (v[3*i+1] & v[3*i+2]);
        o[2*i]     = v[3*i] ^ v[3*i+1] ^ v[3*i+2];
        o[2*i+1]   = {maj[OUT_W-2:0], 1'b0};
      end
    end
    for (int j = 0; j < 2; j++) begin
      if (j < n % 3) o[2*g+j] = v[3*g+j];
    end
    return o;
  endfunction

  function automatic logic [OUT_W-1:0] cpa(input vec_t v);
    return v[0] + v[1];
  endfunction

  logic en;
  vec_t w_ext;

  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  always_comb begin
    w_ext = '0;
    for (int k = 0; k < NOPS; k++) begin
      w_ext[k] = {{(OUT_W-WIDTH){signed_mode & ops[k*WIDTH+WIDTH-1]}}, ops[k*WIDTH +: WIDTH]};
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = lvl_lo(s);
    localparam int HI = lvl_hi(s);

    vec_t w_in;
    vec_t w_red;
    logic w_vin;
    logic r_vld;
`ifdef WT_SUM_ACC_EN
    logic w_min;
`endif

    if (s == 0) begin : g_first
      assign w_in  = w_ext;
      assign w_vin = in_valid;
`ifdef WT_SUM_ACC_EN
      assign w_min = signed_mode;
`endif
    end else begin : g_next
      assign w_in  = g_stage[s-1].g_reg.r_vec;
      assign w_vin = g_stage[s-1].r_vld;
`ifdef WT_SUM_ACC_EN
      assign w_min = g_stage[s-1].g_reg.r_mode;
`endif
    end

    always_comb begin
      w_red = w_in;
      for (int l = 0; l < LEVELS; l++) begin
        if (l >= LO && l < HI) w_red = csa_level(w_red, cnt_at(l));
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  r_vld <= 1'b0;
      else if (en) r_vld <= w_vin;
    end

    if (s < STAGES - 1) begin : g_reg
      vec_t r_vec;
`ifdef WT_SUM_ACC_EN
      logic r_mode;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  r_mode <= 1'b0;
        else if (en) r_mode <= w_min;
      end
`endif
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  r_vec <= '0;
        else if (en) r_vec <= w_red;
      end
    end else begin : g_out
      logic [OUT_W-1:0] w_sum;
      assign w_sum = cpa(w_red);
`ifdef WT_SUM_ACC_EN
      logic [ACC_W-1:0] w_add;
      assign w_add = w_min ? {{(ACC_W-OUT_W){w_sum[OUT_W-1]}}, w_sum}
                           : {{(ACC_W-OUT_W){1'b0}}, w_sum};
      // The result register doubles as the accumulator; acc_clr restarts it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           result <= '0;
        else if (en && w_vin) result <= (acc_clr ? '0 : result) + w_add;
      end
`else
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           result <= '0;
        else if (en && w_vin) result <= w_sum;
      end
`endif
    end
  end

  assign out_valid = g_stage[STAGES-1].r_vld;

endmodule
`default_nettype wire

// File: tb/tb_wt_sum_pipe.sv
`default_nettype none
// Scoreboard bench for wt_sum_pipe (NOPS=4, WIDTH=4, STAGES=2), default build.
module tb_wt_sum_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        signed_mode = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] ops = '0;
  logic        in_ready;
  logic        out_valid;
  logic [5:0]  result;

  wt_sum_pipe #(.NOPS(4), .WIDTH(4), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .signed_mode(signed_mode), .ops(ops), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [5:0] exp; int cyc; bit lat; } sb_t;
  sb_t sb[$];

  logic [5:0] cur_exp = '0;
  bit         lat_chk = 1'b0;

  // Directed vectors: operand 0 is the low nibble.
  logic [15:0] v_ops  [12] = '{16'h7777, 16'h8888, 16'h1F87, 16'hFFFF, 16'h7777, 16'hFFFF,
                               16'h8421, 16'h8421, 16'h5A3C, 16'h5A3C, 16'h1234, 16'h0000};
  bit          v_mode [12] = '{1, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0};
  logic [5:0]  v_exp  [12] = '{6'h1C, 6'h20, 6'h3F, 6'h3C, 6'h1C, 6'h3C,
                               6'h0F, 6'h3F, 6'h1E, 6'h3E, 6'h0A, 6'h00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) sb.push_back('{cur_exp, cyc, lat_chk});
  end

  logic [5:0] held;
  bit         hold_pend = 1'b0;

  always @(negedge clk) begin : p_mon
    sb_t e;
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_result", result, held);
      end
      hold_pend = 1'b0;
      if (out_valid && !out_ready) begin
        held      = result;
        hold_pend = 1'b1;
        chk("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0h with no beat outstanding", result);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.exp);
          if (e.lat) chk("latency", cyc - e.cyc, 2);
        end
      end
    end
  end

  // Streams vectors first..first+num-1; out_ready low during cycles st_lo..st_hi.
  task automatic run(input int first, input int num, input int st_lo, input int st_hi, input bit lat);
    int i;
    int c;
    i = first;
    c = 0;
    while (i < first + num && c < 200) begin
      out_ready   = !(c >= st_lo && c <= st_hi);
      in_valid    = 1'b1;
      signed_mode = v_mode[i];
      ops         = v_ops[i];
      cur_exp     = v_exp[i];
      lat_chk     = lat;
      @(negedge clk);
      if (in_ready) i++;
      @(posedge clk); #1;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (c >= 200) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: accepted %0d of %0d beats", i - first, num);
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results outstanding expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    run(0, 1, 99, 99, 1'b1);
    drain();
    run(0, 12, 99, 99, 1'b1);
    drain();
    run(0, 6, 3, 5, 1'b0);
    drain();

    // Two beats in flight, then an asynchronous reset drops both.
    run(0, 2, 99, 99, 1'b0);
    chk("inflight_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_async_valid", out_valid, 0);
    chk("reset_async_result", result, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rerelease_in_ready", in_ready, 1);
    @(posedge clk); #1;
    run(10, 1, 99, 99, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
